// File: rtl/evf_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : evf_tx_pkg
// Description : Shared constants and types for the EVF TX framer.
//               K-character codes, the null event code and the state type
//               of the optional data-buffer packet FSM (EVF_TX_DATABUF_EN).
// Revision    : 1.0 - initial release
// ============================================================================
package evf_tx_pkg;

  localparam logic [7:0] K28_5   = 8'hBC;  // comma
  localparam logic [7:0] K28_0   = 8'h1C;  // packet start
  localparam logic [7:0] K28_1   = 8'h3C;  // packet end
  localparam logic [7:0] EV_NULL = 8'h00;

  typedef enum logic [2:0] {
    DB_IDLE    = 3'd0,
    DB_START   = 3'd1,
    DB_DATA    = 3'd2,
    DB_CSUM_HI = 3'd3,
    DB_CSUM_LO = 3'd4,
    DB_END     = 3'd5
  } db_state_t;

endpackage
`default_nettype wire

// File: rtl/evf_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : evf_tx_if
// Description : Event handshake, distributed bus byte and MGT TX word of the
//               EVF TX framer. With EVF_TX_DATABUF_EN defined it also carries
//               the data-buffer packet signals.
//   master : event/dbus/buffer source (drives evCode, evValid, dbus, buf*)
//   slave  : framer (drives evReady, txCode, dataIsK, bufRd, bufBusy)
// Revision    : 1.0 - initial release
// ============================================================================
interface evf_tx_if
`ifdef EVF_TX_DATABUF_EN
  #(parameter int BUF_LEN_WIDTH = 11)
`endif
  ;

  logic [7:0]  evCode;
  logic        evValid;
  logic        evReady;
  logic [7:0]  dbus;
  logic [15:0] txCode;
  logic [1:0]  dataIsK;

`ifdef EVF_TX_DATABUF_EN
  logic                     bufStart;
  logic [BUF_LEN_WIDTH-1:0] bufLen;
  logic [7:0]               bufData;
  logic                     bufRd;
  logic                     bufBusy;

  modport master (
    output evCode, evValid, dbus, bufStart, bufLen, bufData,
    input  evReady, txCode, dataIsK, bufRd, bufBusy
  );
  modport slave (
    input  evCode, evValid, dbus, bufStart, bufLen, bufData,
    output evReady, txCode, dataIsK, bufRd, bufBusy
  );
`else
  modport master (
    output evCode, evValid, dbus,
    input  evReady, txCode, dataIsK
  );
  modport slave (
    input  evCode, evValid, dbus,
    output evReady, txCode, dataIsK
  );
`endif

endinterface
`default_nettype wire

// File: rtl/evf_tx_databuf.sv
`default_nettype none
// ============================================================================
// Module      : evf_tx_databuf
// Description : Data-buffer packet engine for the EVF TX framer data slots.
//               Packet = K28.0, payload bytes, checksum hi, checksum lo, K28.1.
//               Checksum is 16'hFFFF minus the 16-bit wrapped payload sum.
//   clk       in  clock (txClk)
//   rst       in  synchronous clear (reset or MGT not ready; aborts packet)
//   slot      in  current cycle is a data slot of a ready link
//   start     in  start request, ignored while busy
//   len       in  payload length, sampled with start
//   data_in   in  first-word-fall-through payload byte
//   rd        out payload byte consumed this cycle
//   busy      out packet in progress
//   data_byte out byte for the data slot (0x00 when idle)
//   data_k    out data_byte is a K character
// Revision    : 1.0 - initial release
// ============================================================================
module evf_tx_databuf
  import evf_tx_pkg::*;
#(
  parameter int BUF_LEN_WIDTH = 11
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     slot,
  input  wire logic                     start,
  input  wire logic [BUF_LEN_WIDTH-1:0] len,
  input  wire logic [7:0]               data_in,
  output logic                          rd,
  output logic                          busy,
  output logic [7:0]                    data_byte,
  output logic                          data_k
);

  db_state_t                r_state;
  logic [BUF_LEN_WIDTH-1:0] r_remain;
  logic [15:0]              r_csum;

  assign busy = (r_state != DB_IDLE);

  // Slot content is decoded from the registered state; the framer registers
  // it into txCode, and rd must coincide with the byte being used.
  always_comb begin
    data_byte = EV_NULL;
    data_k    = 1'b0;
    rd        = 1'b0;
    if (slot) begin
      case (r_state)
        DB_START:   begin data_byte = K28_0; data_k = 1'b1; end
        DB_DATA:    begin data_byte = data_in; rd = 1'b1; end
        DB_CSUM_HI: data_byte = r_csum[15:8];
        DB_CSUM_LO: data_byte = r_csum[7:0];
        DB_END:     begin data_byte = K28_1; data_k = 1'b1; end
        default:    data_byte = EV_NULL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DB_IDLE;
      r_remain <= '0;
      r_csum   <= 16'hFFFF;
    end else begin
      case (r_state)
        DB_IDLE: if (start) begin
          r_state  <= DB_START;
          r_remain <= len;
          r_csum   <= 16'hFFFF;
        end
        DB_START: if (slot) begin
          r_state <= (r_remain == '0) ? DB_CSUM_HI : DB_DATA;
        end
        DB_DATA: if (slot) begin
          r_csum   <= r_csum - {8'h00, data_in};
          r_remain <= r_remain - 1'b1;
          if (r_remain == BUF_LEN_WIDTH'(1)) r_state <= DB_CSUM_HI;
        end
        DB_CSUM_HI: if (slot) r_state <= DB_CSUM_LO;
        DB_CSUM_LO: if (slot) r_state <= DB_END;
        DB_END:     if (slot) r_state <= DB_IDLE;
        default:    r_state <= DB_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/evf_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : evf_tx_framer
// Description : EVF MGT TX framer. Each txClk cycle builds a registered
//               16-bit word: upper byte = heartbeat / accepted event / null,
//               lower byte = dbus, data slot or K28.5 comma (last frame slot).
//               Optional data-buffer packets in data slots: EVF_TX_DATABUF_EN.
//   txClk    in  MGT TX user clock
//   txReset  in  synchronous active-high reset
//   mgtReady in  MGT wrapper ready
//   bus      slave modport of evf_tx_if (events, dbus, txCode, dataIsK, buf*)
// Revision    : 1.0 - initial release
// ============================================================================
module evf_tx_framer
  import evf_tx_pkg::*;
#(
  parameter int         COMMA_PERIOD = 4,
  parameter int         HB_INTERVAL  = 124916000,
  parameter logic [7:0] HB_CODE      = 8'h7A
`ifdef EVF_TX_DATABUF_EN
  ,
  parameter int         BUF_LEN_WIDTH = 11
`endif
) (
  input  wire logic txClk,
  input  wire logic txReset,
  input  wire logic mgtReady,
  evf_tx_if.slave   bus
);

  localparam int              FC_W    = $clog2(COMMA_PERIOD);
  localparam int              HB_W    = $clog2(HB_INTERVAL);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(COMMA_PERIOD - 1);
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_INTERVAL - 1);

  logic [FC_W-1:0] r_fc;
  logic [HB_W-1:0] r_hb_cnt;
  logic [15:0]     r_tx_code;
  logic [1:0]      r_data_is_k;

  logic       w_ready;
  logic       w_hb_due;
  logic       w_ev_take;
  logic       w_comma_slot;
  logic       w_data_slot;
  logic [7:0] w_db_byte;
  logic       w_db_k;
  logic [7:0] w_hi;
  logic [7:0] w_lo;
  logic       w_k_lo;

  assign w_ready      = mgtReady & ~txReset;
  assign w_hb_due     = (r_hb_cnt == HB_LAST);
  assign bus.evReady  = w_ready & ~w_hb_due;
  assign w_ev_take    = bus.evValid & bus.evReady;
  assign w_comma_slot = (r_fc == FC_LAST);
  // COMMA_PERIOD is even, so the comma slot is odd; remaining odd slots carry data.
  assign w_data_slot  = r_fc[0] & ~w_comma_slot;

`ifdef EVF_TX_DATABUF_EN
  evf_tx_databuf #(
    .BUF_LEN_WIDTH (BUF_LEN_WIDTH)
  ) u_databuf (
    .clk       (txClk),
    .rst       (~w_ready),
    .slot      (w_ready & w_data_slot),
    .start     (bus.bufStart),
    .len       (bus.bufLen),
    .data_in   (bus.bufData),
    .rd        (bus.bufRd),
    .busy      (bus.bufBusy),
    .data_byte (w_db_byte),
    .data_k    (w_db_k)
  );
`else
  assign w_db_byte = EV_NULL;
  assign w_db_k    = 1'b0;
`endif

  always_comb begin
    w_lo   = EV_NULL;
    w_k_lo = 1'b0;
    if (w_comma_slot) begin
      w_lo   = K28_5;
      w_k_lo = 1'b1;
    end else if (w_data_slot) begin
      w_lo   = w_db_byte;
      w_k_lo = w_db_k;
    end else begin
      w_lo   = bus.dbus;
    end
    // A heartbeat wins the slot; evReady is low then, so the user event waits.
    w_hi = w_hb_due ? HB_CODE : (w_ev_take ? bus.evCode : EV_NULL);
  end

  always_ff @(posedge txClk) begin
    if (!w_ready) begin
      r_fc        <= '0;
      r_hb_cnt    <= '0;
      r_tx_code   <= {EV_NULL, K28_5};
      r_data_is_k <= 2'b01;
    end else begin
      r_fc        <= w_comma_slot ? '0 : r_fc + 1'b1;
      r_hb_cnt    <= w_hb_due ? '0 : r_hb_cnt + 1'b1;
      r_tx_code   <= {w_hi, w_lo};
      r_data_is_k <= {1'b0, w_k_lo};
    end
  end

  assign bus.txCode  = r_tx_code;
  assign bus.dataIsK = r_data_is_k;

endmodule
`default_nettype wire

// File: tb/tb_evf_tx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_evf_tx_framer
// Description : Directed self-checking bench for evf_tx_framer
//               (COMMA_PERIOD=4, HB_INTERVAL=16). Packet scenarios are
//               built when EVF_TX_DATABUF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_evf_tx_framer;

  logic txClk = 1'b0;
  logic txReset;
  logic mgtReady;
  int   n_vec = 0;
  int   n_err = 0;

`ifdef EVF_TX_DATABUF_EN
  evf_tx_if #(.BUF_LEN_WIDTH(11)) bus ();
`else
  evf_tx_if bus ();
`endif

  evf_tx_framer #(
    .COMMA_PERIOD (4),
    .HB_INTERVAL  (16),
    .HB_CODE      (8'h7A)
`ifdef EVF_TX_DATABUF_EN
    ,
    .BUF_LEN_WIDTH (11)
`endif
  ) dut (
    .txClk    (txClk),
    .txReset  (txReset),
    .mgtReady (mgtReady),
    .bus      (bus)
  );

  always #5 txClk = ~txClk;

  task automatic step();
    @(posedge txClk);
    #1;
  endtask

  // Two not-ready edges clear everything; the next edge is frame slot 0.
  task automatic restart();
    txReset     = 1'b0;
    mgtReady    = 1'b0;
    bus.evValid = 1'b0;
    step();
    step();
    mgtReady = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    txReset = 1'b1; mgtReady = 1'b1;
    bus.evValid = 1'b1; bus.evCode = 8'h55; bus.dbus = 8'h33;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++;
      if (bus.txCode !== 16'h00BC || bus.dataIsK !== 2'b01) begin
        n_err++;
        $display("FAIL reset_word got %h/%b want 00bc/01", bus.txCode, bus.dataIsK);
      end
      n_vec++;
      if (bus.evReady !== 1'b0) begin
        n_err++;
        $display("FAIL reset_evready got %b want 0", bus.evReady);
      end
    end
  endtask

  task automatic test_not_ready();
    txReset = 1'b0; mgtReady = 1'b0;
    bus.evValid = 1'b1; bus.evCode = 8'h66;
    for (int k = 0; k < 4; k++) begin
      step();
      n_vec++;
      if (bus.txCode !== 16'h00BC || bus.dataIsK !== 2'b01 || bus.evReady !== 1'b0) begin
        n_err++;
        $display("FAIL not_ready got %h/%b/%b want 00bc/01/0",
                 bus.txCode, bus.dataIsK, bus.evReady);
      end
    end
  endtask

  task automatic test_idle_pattern();
    logic [7:0] exp_lo;
    logic [1:0] exp_k;
    restart();
    bus.dbus = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_lo = (k % 4 == 3) ? 8'hBC : ((k % 2 == 0) ? 8'hA5 : 8'h00);
      exp_k  = (k % 4 == 3) ? 2'b01 : 2'b00;
      n_vec++;
      if (bus.txCode !== {8'h00, exp_lo} || bus.dataIsK !== exp_k) begin
        n_err++;
        $display("FAIL idle_slot%0d got %h/%b want %h/%b",
                 k, bus.txCode, bus.dataIsK, {8'h00, exp_lo}, exp_k);
      end
    end
  endtask

  task automatic test_event();
    restart();
    bus.dbus = 8'h00;
    step();
    step();
    bus.evCode = 8'h42; bus.evValid = 1'b1;
    n_vec++;
    if (bus.evReady !== 1'b1) begin
      n_err++;
      $display("FAIL event_ready got %b want 1", bus.evReady);
    end
    step();
    bus.evValid = 1'b0;
    n_vec++;
    if (bus.txCode !== 16'h4200) begin
      n_err++;
      $display("FAIL event_sent got %h want 4200", bus.txCode);
    end
    step();
    n_vec++;
    if (bus.txCode !== 16'h00BC || bus.dataIsK !== 2'b01) begin
      n_err++;
      $display("FAIL event_after got %h/%b want 00bc/01", bus.txCode, bus.dataIsK);
    end
    // A user code of 0x00 is accepted and goes out as a plain null.
    bus.evCode = 8'h00; bus.evValid = 1'b1; bus.dbus = 8'h3C;
    n_vec++;
    if (bus.evReady !== 1'b1) begin
      n_err++;
      $display("FAIL null_ready got %b want 1", bus.evReady);
    end
    step();
    bus.evValid = 1'b0;
    n_vec++;
    if (bus.txCode !== 16'h003C || bus.dataIsK !== 2'b00) begin
      n_err++;
      $display("FAIL null_event got %h/%b want 003c/00", bus.txCode, bus.dataIsK);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_w [4];
    exp_w = '{16'h115A, 16'h2200, 16'h335A, 16'h00BC};
    restart();
    bus.dbus = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      bus.evValid = (k < 3);
      bus.evCode  = 8'((k + 1) * 8'h11);
      step();
      n_vec++;
      if (bus.txCode !== exp_w[k]) begin
        n_err++;
        $display("FAIL b2b_%0d got %h want %h", k, bus.txCode, exp_w[k]);
      end
    end
  endtask

  task automatic test_heartbeat();
    logic       exp_rdy;
    logic [7:0] exp_hi;
    logic [7:0] exp_lo;
    restart();
    bus.dbus = 8'h00;
    bus.evCode = 8'h10;
    for (int k = 0; k < 32; k++) begin
      bus.evValid = (k <= 16);
      exp_rdy = (k % 16 != 15);
      n_vec++;
      if (bus.evReady !== exp_rdy) begin
        n_err++;
        $display("FAIL hb_evready_%0d got %b want %b", k, bus.evReady, exp_rdy);
      end
      step();
      exp_hi = (k % 16 == 15) ? 8'h7A : ((k <= 16) ? 8'h10 : 8'h00);
      exp_lo = (k % 4 == 3) ? 8'hBC : 8'h00;
      n_vec++;
      if (bus.txCode !== {exp_hi, exp_lo}) begin
        n_err++;
        $display("FAIL hb_word_%0d got %h want %h", k, bus.txCode, {exp_hi, exp_lo});
      end
    end
    bus.evValid = 1'b0;
  endtask

`ifdef EVF_TX_DATABUF_EN
  task automatic test_packet();
    logic [8:0] exp_tbl [7];
    logic [7:0] pl [4];
    int idx;
    int n_rd;
    logic rd;
    exp_tbl = '{9'h11C, 9'h001, 9'h002, 9'h003, 9'h0FF, 9'h0F9, 9'h13C};
    pl = '{8'h01, 8'h02, 8'h03, 8'hEE};
    restart();
    bus.dbus = 8'h77;
    idx = 0; n_rd = 0;
    bus.bufLen = 11'd3; bus.bufStart = 1'b1; bus.bufData = pl[0];
    for (int k = 0; k < 28; k++) begin
      rd = bus.bufRd;
      if (rd) n_rd++;
      step();
      bus.bufStart = 1'b0;
      if (rd && idx < 3) idx++;
      bus.bufData = pl[idx];
      if (k % 4 == 1) begin
        n_vec++;
        if ({bus.dataIsK[0], bus.txCode[7:0]} !== exp_tbl[k / 4]) begin
          n_err++;
          $display("FAIL pkt_slot%0d got %h want %h", k / 4,
                   {bus.dataIsK[0], bus.txCode[7:0]}, exp_tbl[k / 4]);
        end
      end else if (k % 4 != 3) begin
        n_vec++;
        if (bus.txCode[7:0] !== 8'h77) begin
          n_err++;
          $display("FAIL pkt_dbus_%0d got %h want 77", k, bus.txCode[7:0]);
        end
      end
      if (k == 0 || k == 24 || k == 25) begin
        n_vec++;
        if (bus.bufBusy !== (k != 25)) begin
          n_err++;
          $display("FAIL pkt_busy_%0d got %b want %b", k, bus.bufBusy, k != 25);
        end
      end
    end
    n_vec++;
    if (n_rd != 3) begin
      n_err++;
      $display("FAIL pkt_rd_count got %0d want 3", n_rd);
    end
  endtask

  task automatic test_abort();
    logic [8:0] exp_tbl [4];
    exp_tbl = '{9'h11C, 9'h0FF, 9'h0FF, 9'h13C};
    restart();
    bus.dbus = 8'h00;
    bus.bufLen = 11'd3; bus.bufStart = 1'b1; bus.bufData = 8'h01;
    for (int k = 0; k < 6; k++) begin
      step();
      bus.bufStart = 1'b0;
    end
    n_vec++;
    if (bus.txCode[7:0] !== 8'h01) begin
      n_err++;
      $display("FAIL abort_first_byte got %h want 01", bus.txCode[7:0]);
    end
    mgtReady = 1'b0;
    step();
    n_vec++;
    if (bus.txCode !== 16'h00BC || bus.dataIsK !== 2'b01 || bus.bufBusy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_idle got %h/%b/%b want 00bc/01/0",
               bus.txCode, bus.dataIsK, bus.bufBusy);
    end
    restart();
    bus.bufLen = 11'd0; bus.bufStart = 1'b1; bus.bufData = 8'hEE;
    for (int k = 0; k < 14; k++) begin
      step();
      bus.bufStart = 1'b0;
      if (k % 4 == 1) begin
        n_vec++;
        if ({bus.dataIsK[0], bus.txCode[7:0]} !== exp_tbl[k / 4]) begin
          n_err++;
          $display("FAIL restart_slot%0d got %h want %h", k / 4,
                   {bus.dataIsK[0], bus.txCode[7:0]}, exp_tbl[k / 4]);
        end
      end
    end
  endtask
`endif

  initial begin
    txReset = 1'b1; mgtReady = 1'b0;
    bus.evCode = 8'h00; bus.evValid = 1'b0; bus.dbus = 8'h00;
`ifdef EVF_TX_DATABUF_EN
    bus.bufStart = 1'b0; bus.bufLen = '0; bus.bufData = 8'h00;
`endif
    test_reset();
    test_not_ready();
    test_idle_pattern();
    test_event();
    test_back_to_back();
    test_heartbeat();
`ifdef EVF_TX_DATABUF_EN
    test_packet();
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
